// File: rtl/fifo_rd_arb_pkg.sv
// fifo_rd_arb_pkg
// Shared definitions for the FIFO read arbiter:
//   state_t   - arbiter FSM encoding (IDLE, GRANT)
//   ch_width  - width of a channel index, never less than one bit
package fifo_rd_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int ch_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_arb_skid.sv
// fifo_rd_arb_skid
// Two-entry output buffer for the read arbiter. Words arrive one cycle after
// the FIFO read that fetched them and leave in arrival order. The head entry
// is held steady on data/ch while valid && !ready.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   push, push_data,
//   push_ch           - word returning from a FIFO read, with its channel tag
//   ready             - downstream accept
//   valid, data, ch   - head entry presented downstream
//   occ               - number of entries held (0..2)
module fifo_rd_arb_skid #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_W       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [CH_W-1:0]       push_ch,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [CH_W-1:0]       ch,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] d0, d1;
    logic [CH_W-1:0]       c0, c1;
    logic [1:0]            cnt;
    logic                  pop;

    assign valid = (cnt != 2'd0);
    assign pop   = valid && ready;
    assign data  = d0;
    assign ch    = c0;
    assign occ   = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 2'd0;
            d0  <= '0;
            d1  <= '0;
            c0  <= '0;
            c1  <= '0;
        end else begin
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                if (cnt == 2'd2) begin
                    // second entry moves to the head; a new word fills behind it
                    d0 <= d1;
                    c0 <= c1;
                    if (push) begin
                        d1 <= push_data;
                        c1 <= push_ch;
                    end
                end else if (push) begin
                    // single entry leaves while the next one arrives
                    d0 <= push_data;
                    c0 <= push_ch;
                end
            end else if (push) begin
                if (cnt == 2'd0) begin
                    d0 <= push_data;
                    c0 <= push_ch;
                end else begin
                    d1 <= push_data;
                    c1 <= push_ch;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arb.sv
// fifo_rd_arb
// Round-robin arbiter that drains NUM_CH FIFO read ports into one
// valid/ready output stream. A grant reads up to a per-grant word limit from
// one channel; reads are throttled so that every fetched word has a slot in
// the two-entry output buffer.
// Build option: define FIFO_RD_ARB_BURST_EN to read up to BURST_LEN words per
// grant; without it every grant reads a single word (strict per-word
// round-robin).
// Ports:
//   rd_clk, rd_rst    - clock, asynchronous active-high reset
//   ch_empty          - per-channel FIFO empty
//   ch_almost_empty   - per-channel FIFO almost empty (limits grant to 1 word)
//   ch_rd_data        - per-channel read data, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ch_rd_en          - per-channel read enable, one-hot or zero
//   out_valid, out_ready, out_data, out_ch - output stream and source channel
module fifo_rd_arb
    import fifo_rd_arb_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int BURST_LEN  = 4,
    localparam int CH_W       = ch_width(NUM_CH)
) (
    input  logic                         rd_clk,
    input  logic                         rd_rst,
    input  logic [NUM_CH-1:0]            ch_empty,
    input  logic [NUM_CH-1:0]            ch_almost_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rd_data,
    output logic [NUM_CH-1:0]            ch_rd_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
`ifdef FIFO_RD_ARB_BURST_EN
    localparam int BURST_MAX = BURST_LEN;
`else
    localparam int BURST_MAX = 1;
`endif

    state_t            state, state_nxt;
    logic [CH_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CH_W-1:0]   gnt, gnt_nxt, gnt_succ;
    logic [CH_W-1:0]   pick;
    logic              pick_vld;
    logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc, limit;
    logic              ae_lock, ae_lock_nxt;
    logic              infl;
    logic [CH_W-1:0]   infl_ch;
    logic [1:0]        occ;
    logic [2:0]        busy;
    logic              pop, credit, rd;

    // First non-empty channel at or after rr_ptr. Scanning from the far end
    // lets the nearest candidate overwrite the others.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = rr_ptr;
        pick_vld = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!ch_empty[idx]) begin
                pick     = CH_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    // A word popped this cycle frees its slot for a read issued this cycle.
    assign pop    = out_valid && out_ready;
    assign busy   = 3'(occ) + 3'(infl) - 3'(pop);
    assign credit = (busy < 3'd2);

    assign cnt_inc  = cnt + CNT_W'(1);
    assign limit    = ae_lock ? CNT_W'(1) : CNT_W'(BURST_MAX);
    assign gnt_succ = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        cnt_nxt     = cnt;
        ae_lock_nxt = ae_lock;
        rr_ptr_nxt  = rr_ptr;
        rd          = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt   = GRANT;
                    gnt_nxt     = pick;
                    cnt_nxt     = '0;
                    ae_lock_nxt = ch_almost_empty[pick];
                end
            end
            GRANT: begin
                if (ch_empty[gnt]) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = gnt_succ;
                end else if (credit) begin
                    rd      = 1'b1;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc >= limit) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = gnt_succ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ch_rd_en      = '0;
        ch_rd_en[gnt] = rd;
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt     <= '0;
            cnt     <= '0;
            ae_lock <= 1'b0;
            infl    <= 1'b0;
            infl_ch <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            gnt     <= gnt_nxt;
            cnt     <= cnt_nxt;
            ae_lock <= ae_lock_nxt;
            infl    <= rd;
            infl_ch <= gnt;
        end
    end

    fifo_rd_arb_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .CH_W       (CH_W)
    ) u_skid (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (infl),
        .push_data (ch_rd_data[infl_ch*DATA_WIDTH +: DATA_WIDTH]),
        .push_ch   (infl_ch),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (out_data),
        .ch        (out_ch),
        .occ       (occ)
    );

endmodule

// File: tb/tb_fifo_rd_arb.sv
// tb_fifo_rd_arb
// Directed bench for fifo_rd_arb: behavioural FIFOs per channel, an output
// collector, and hand-derived expected word orders for both build options
// (FIFO_RD_ARB_BURST_EN defined or not).
module tb_fifo_rd_arb;

    localparam int NUM_CH = 4;
    localparam int DW     = 16;
    localparam int CH_W   = 2;

    logic                   rd_clk = 1'b0;
    logic                   rd_rst;
    logic [NUM_CH-1:0]      ch_empty, ch_almost_empty, ch_rd_en;
    logic [NUM_CH*DW-1:0]   ch_rd_data;
    logic                   out_valid, out_ready;
    logic [DW-1:0]          out_data;
    logic [CH_W-1:0]        out_ch;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_arb #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .BURST_LEN(4)) dut (
        .rd_clk          (rd_clk),
        .rd_rst          (rd_rst),
        .ch_empty        (ch_empty),
        .ch_almost_empty (ch_almost_empty),
        .ch_rd_data      (ch_rd_data),
        .ch_rd_en        (ch_rd_en),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_ch          (out_ch)
    );

    logic [DW-1:0]     q [NUM_CH][$];
    logic [NUM_CH-1:0] ae_mask, rd_s;
    logic [3:0]        rdy_pat = 4'b1001;   // 1,0,0,1 repeating
    int                rdy_mode, cyc;
    int                got[$], exp_q[$], rd_cyc[$];
    int                n_cmp, n_err;
    int                stall_err, onehot_err, underflow, outstanding, max_out;
    logic              prev_stall;
    logic [DW-1:0]     prev_data;
    logic [CH_W-1:0]   prev_ch;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int w(input int c, input int i);
        return c * 65536 + c * 256 + i;
    endfunction

    task automatic upd();
        for (int k = 0; k < NUM_CH; k++) ch_empty[k] = (q[k].size() == 0);
        ch_almost_empty = ae_mask;
    endtask

    task automatic load(input int c, input int n);
        for (int i = 0; i < n; i++) q[c].push_back(DW'(c * 256 + i));
        upd();
    endtask

    // FIFO model: data/flags change just after the edge that performs the read
    always @(posedge rd_clk) begin
        #1;
        cyc++;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_s[k]) begin
                if (q[k].size() > 0) ch_rd_data[k*DW +: DW] = q[k].pop_front();
                else underflow++;
            end
        end
        upd();
        out_ready = (rdy_mode != 0) ? rdy_pat[cyc % 4] : 1'b1;
    end

    // Output collector and protocol monitors, sampled mid-cycle
    always @(negedge rd_clk) begin
        rd_s = ch_rd_en;
        if (rd_rst) begin
            prev_stall = 1'b0;
        end else begin
            if ($countones(ch_rd_en) > 1) onehot_err++;
            if (|ch_rd_en) rd_cyc.push_back(cyc);
            if (prev_stall && (!out_valid || out_data !== prev_data || out_ch !== prev_ch))
                stall_err++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_ch    = out_ch;
            outstanding += $countones(ch_rd_en);
            if (out_valid && out_ready) begin
                got.push_back(int'(out_ch) * 65536 + int'(out_data));
                outstanding--;
            end
            if (outstanding > max_out) max_out = outstanding;
        end
    end

    task automatic do_reset();
        @(negedge rd_clk);
        rd_rst   = 1'b1;
        rdy_mode = 0;
        out_ready = 1'b1;
        ae_mask  = '0;
        for (int k = 0; k < NUM_CH; k++) q[k].delete();
        ch_rd_data = '0;
        upd();
        repeat (2) @(negedge rd_clk);
        got.delete(); exp_q.delete(); rd_cyc.delete();
        outstanding = 0; max_out = 0; stall_err = 0;
        rd_rst = 1'b0;
    endtask

    task automatic wait_n(input int n, input int budget);
        int c;
        c = 0;
        while (got.size() < n && c < budget) begin
            @(negedge rd_clk);
            c++;
        end
        repeat (6) @(negedge rd_clk);
    endtask

    task automatic cmp_got(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; rdy_mode = 0;
        stall_err = 0; onehot_err = 0; underflow = 0; outstanding = 0; max_out = 0;
        prev_stall = 1'b0; rd_s = '0; ae_mask = '0; out_ready = 1'b1;
        ch_rd_data = '0;
        rd_rst = 1'b1;
        upd();

        // reset state
        repeat (2) @(negedge rd_clk);
        chk("rst_rd_en", ch_rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);

        // single channel, 10 words
        do_reset();
        load(1, 10);
        for (int i = 0; i < 10; i++) exp_q.push_back(w(1, i));
        wait_n(10, 200);
        cmp_got("ch1_only");
        chk("ch1_reads", rd_cyc.size(), 10);
        for (int i = 0; i + 1 < rd_cyc.size() && i < 9; i++) begin
`ifdef FIFO_RD_ARB_BURST_EN
            chk($sformatf("ch1_gap[%0d]", i), rd_cyc[i+1] - rd_cyc[i], ((i % 4) == 3) ? 2 : 1);
`else
            chk($sformatf("ch1_gap[%0d]", i), rd_cyc[i+1] - rd_cyc[i], 2);
`endif
        end

        // all channels, 8 words each
        do_reset();
        for (int c = 0; c < NUM_CH; c++) load(c, 8);
`ifdef FIFO_RD_ARB_BURST_EN
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NUM_CH; c++)
                for (int j = 0; j < 4; j++) exp_q.push_back(w(c, r * 4 + j));
`else
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < NUM_CH; c++) exp_q.push_back(w(c, i));
`endif
        wait_n(32, 400);
        cmp_got("all_ch");

        // back-pressure with out_ready 1,0,0,1
        do_reset();
        rdy_mode = 1;
        load(2, 6);
        for (int i = 0; i < 6; i++) exp_q.push_back(w(2, i));
        wait_n(6, 200);
        cmp_got("stall");
        chk("stall_hold_err", stall_err, 0);
        chk("stall_max_outstanding_le2", max_out <= 2, 1);

        // almost-empty channel yields after one word
        do_reset();
        ae_mask = 4'b0001;
        load(0, 2);
        load(3, 5);
`ifdef FIFO_RD_ARB_BURST_EN
        exp_q = '{w(0,0), w(3,0), w(3,1), w(3,2), w(3,3), w(0,1), w(3,4)};
`else
        exp_q = '{w(0,0), w(3,0), w(0,1), w(3,1), w(3,2), w(3,3), w(3,4)};
`endif
        wait_n(7, 200);
        cmp_got("almost_empty");

        // reset in the middle of a burst on ch1
        do_reset();
        load(1, 8);
        begin
            int c;
            c = 0;
            while (rd_cyc.size() < 2 && c < 50) begin
                @(negedge rd_clk);
                c++;
            end
        end
        chk("midrst_started", rd_cyc.size() >= 2, 1);
        #2 rd_rst = 1'b1;
        @(negedge rd_clk);
        chk("midrst_rd_en", ch_rd_en, 0);
        chk("midrst_out_valid", out_valid, 0);
        load(0, 2);
        got.delete();
        outstanding = 0;
        @(negedge rd_clk);
        rd_rst = 1'b0;
        wait_n(2, 100);
        chk("midrst_words", got.size() >= 2, 1);
        if (got.size() >= 2) begin
            chk("midrst_first", got[0], w(0, 0));
`ifdef FIFO_RD_ARB_BURST_EN
            chk("midrst_second", got[1], w(0, 1));
`else
            chk("midrst_second_ch", got[1] / 65536, 1);
`endif
        end

        // two channels, 3 words each
        do_reset();
        load(0, 3);
        load(1, 3);
`ifdef FIFO_RD_ARB_BURST_EN
        exp_q = '{w(0,0), w(0,1), w(0,2), w(1,0), w(1,1), w(1,2)};
`else
        exp_q = '{w(0,0), w(1,0), w(0,1), w(1,1), w(0,2), w(1,2)};
`endif
        wait_n(6, 100);
        cmp_got("two_ch");

        chk("onehot_err", onehot_err, 0);
        chk("underflow", underflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_arb.md
FIFO_RD_ARB -- requirements
Module: fifo_rd_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of FIFO read ports arbitrated (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16: FIFO word width.
REQ-003 SHALL have parameter BURST_LEN, default 4: maximum words read per grant (1..16).
REQ-004 SHALL have port rd_clk  input  1  read-domain clock; one clock, all logic rising-edge.
REQ-005 SHALL have port rd_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ch_empty  input  NUM_CH  per-channel FIFO empty flag.
REQ-007 SHALL have port ch_almost_empty  input  NUM_CH  per-channel FIFO almost-empty flag.
REQ-008 SHALL have port ch_rd_data  input  NUM_CH*DATA_WIDTH  per-channel FIFO read data; channel k in bits [k*DATA_WIDTH +: DATA_WIDTH]; valid one cycle after that channel's rd_en.
REQ-009 SHALL have port ch_rd_en  output  NUM_CH  per-channel FIFO read enable; at most one bit high per cycle.
REQ-010 SHALL have port out_valid  output  1  output word valid.
REQ-011 SHALL have port out_ready  input  1  downstream accept; transfer when out_valid && out_ready.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  output word.
REQ-013 SHALL have port out_ch  output  CH_W = max(1, clog2(NUM_CH))  source channel of out_data.

Function
REQ-014 SHALL implement states IDLE and GRANT; IDLE->GRANT when any ch_empty bit is 0, selecting the first non-empty channel at or after rr_ptr (round-robin, wrap from NUM_CH-1 to 0).
REQ-015 SHALL, in GRANT, assert ch_rd_en[g] in a cycle only if ch_empty[g]==0 and credit is available (REQ-017); a burst counter SHALL increment on each issued read.
REQ-016 SHALL leave GRANT for IDLE on the cycle after the read that makes count==BURST_LEN, or immediately when ch_empty[g]==1, or after one read if ch_almost_empty[g]==1 at grant time; on leaving, rr_ptr SHALL become (g+1) mod NUM_CH.
REQ-017 SHALL contain a 2-entry output skid buffer; a read SHALL issue only when (occupancy + reads in flight) < 2, counting an entry that is popped in the same cycle as freed.
REQ-018 SHALL capture ch_rd_data[g] and tag g into the skid buffer exactly one cycle after ch_rd_en[g]; out_data/out_ch SHALL present the oldest entry, in read order.
REQ-019 SHALL sustain one word per cycle from a single channel when out_ready is held high.
REQ-020 SHALL never drop or duplicate a word under arbitrary out_ready toggling; out_data/out_ch SHALL hold stable while out_valid && !out_ready.
REQ-021 SHALL not issue ch_rd_en to a non-granted channel, and SHALL not issue reads while in IDLE.

Reset
REQ-022 SHALL, while rd_rst is high, force state IDLE, rr_ptr=0, burst count=0, skid occupancy=0, in-flight=0, ch_rd_en=0, out_valid=0, out_data=0, out_ch=0.
REQ-023 SHALL discard in-flight reads and buffered words when reset asserts mid-burst; first grant after release SHALL start at channel 0.

Configuration
REQ-024 SHALL, with macro FIFO_RD_ARB_BURST_EN defined, behave as REQ-015..016 with BURST_LEN words per grant.
REQ-025 SHALL, without FIFO_RD_ARB_BURST_EN, read exactly one word per grant (BURST_LEN ignored), giving strict per-word round-robin.

Structure
REQ-026 SHALL place CH_W computation and the state encoding (IDLE, GRANT) in shared package fifo_rd_arb_pkg.
REQ-027 SHALL implement the 2-entry output buffer as sub-module fifo_rd_arb_skid; arbitration and FSM SHALL remain in fifo_rd_arb.

Verification
REQ-028 Ch1 holds 10 words, others empty, out_ready=1, burst on -> reads in bursts of 4,4,2; 10 words on consecutive cycles except 1-cycle IDLE gaps; out_ch=1 throughout.
REQ-029 All 4 channels hold 8 words, out_ready=1, burst on -> grant order 0,1,2,3,0,1,2,3, 4 words each; 32 words in per-channel order.
REQ-030 Ch2 holds 6 words, out_ready toggles 1,0,0,1 repeating -> all 6 words delivered in order, never >2 outstanding, outputs stable while stalled.
REQ-031 Ch0 almost_empty=1 with 2 words, ch3 holds 5 -> ch0 grant reads 1 word, next grant goes to ch3.
REQ-032 rd_rst pulsed mid-burst on ch1 -> next cycle ch_rd_en=0, out_valid=0; after release, grant starts at ch0 if non-empty.
REQ-033 Macro undefined, ch0 and ch1 hold 3 words each -> output channel sequence 0,1,0,1,0,1.
